apb_arbiter_master: RTL and testbench
=====================================

# apb_arbiter_master

Two-port APB master that shares one APB slave (256 x 32-bit register file) between two requesters. It arbitrates round-robin, sequences the APB SETUP and ACCESS phases, waits for PREADY, and returns read data and a completion pulse to the granted requester. It sits between the local requesters (CPU bridge and DMA) and the slave's PSEL/PENABLE/PADDR/PWRITE/PWDATA inputs.

## Interface
Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, maximum ACCESS cycles without PREADY (used only with the timeout feature)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset, asynchronous, active-low
- req0_valid, req1_valid  in  1  request pending; held with stable fields until the matching done
- req0_write, req1_write  in  1  1 = write, 0 = read
- req0_addr, req1_addr  in  ADDR_W  target address
- req0_wdata, req1_wdata  in  DATA_W  write data
- req0_done, req1_done  out  1  one-cycle completion pulse
- req0_rdata, req1_rdata  out  DATA_W  read data, valid while the matching done is high
- req0_err, req1_err  out  1  timeout error, valid while the matching done is high
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PREADY  in  1  slave ready
- PRDATA  in  DATA_W  slave read data

## Operation
- FSM states:
  - IDLE: PSEL=0, PENABLE=0. If any eligible valid is present, latch the winner's write/addr/wdata into PWRITE/PADDR/PWDATA, record the grant, and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Always go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. If PREADY=1, capture PRDATA into the granted rdata (writes capture 0), pulse done next cycle, and go to IDLE. Otherwise stay.
- Eligibility: a requester whose done is high in the current cycle is excluded from arbitration in that cycle. This prevents re-granting a request the requester is still dropping.
- Round-robin: a last-grant pointer is updated on each grant. When both requesters are eligible, the one not last granted wins. The pointer resets to 1, so req0 wins the first tie.
- PADDR/PWRITE/PWDATA are stable from SETUP through the end of ACCESS. They hold their value in IDLE and are not cleared.
- PREADY is ignored outside ACCESS. The slave's PREADY may still be high in the first cycle of the next transfer.
- Outputs are all registered; there are no combinational paths from req inputs to APB outputs.
- Reset (asynchronous, any state): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, all done, rdata and err = 0; pointer=1. An in-flight transfer is abandoned with no done.

## Timing
- A valid sampled in IDLE at edge E gives SETUP in cycle E+1 and ACCESS from cycle E+2.
- The registered-PREADY slave raises PREADY in cycle E+3; completion occurs at the end of E+3. done and rdata are high in cycle E+4 (IDLE).
- Next arbitration is at the end of E+4. Sustained throughput is one transfer per 4 cycles with a zero-wait slave; each extra PREADY-low cycle adds one.
- done is high for exactly one cycle per accepted request.
- Simultaneous valids: one grant per IDLE cycle; the loser stays pending and is served in the next transfer.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT, the transfer completes with err=1 and rdata=0, and the FSM returns to IDLE.
  - PREADY=1 on the same cycle as the limit takes priority: normal completion, err=0.
- APB_ARB_TIMEOUT_EN undefined: ACCESS waits indefinitely. Both err outputs are tied 0 and the counter is absent.

## Test plan
- Write: req0 write addr 0x10 data 0xDEADBEEF, zero-wait slave -> PSEL in cycle 1, PENABLE in cycles 2-3, req0_done in cycle 4, slave mem[0x10]=0xDEADBEEF.
- Read-back: req1 reads 0x10 -> req1_done for one cycle with req1_rdata=0xDEADBEEF, req1_err=0; req0_done stays 0.
- Contention: req0 and req1 held valid for 3 requests each -> grants alternate req0, req1, req0, req1, req0, req1; no double grant; done pulses spaced 4 cycles apart.
- Wait states: PREADY held low 5 extra cycles -> PSEL/PENABLE/PADDR stable throughout, done 5 cycles later than nominal.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT=16): PREADY stuck low -> done with err=1 and rdata=0 after 16 ACCESS cycles; the next request completes normally.
- Reset asserted mid-ACCESS -> PSEL/PENABLE drop to 0 asynchronously, no done; after release, a pending req1 tie still grants req0 first.

Source files
------------

// File: rtl/apb_arbiter_master_if.sv
// Requester and APB bus signals of apb_arbiter_master.
// The master modport is the arbiter's side; the slave modport is the environment's side.
interface apb_arbiter_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_write;
  logic              req1_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [DATA_W-1:0] req1_wdata;
  logic              req0_done;
  logic              req1_done;
  logic [DATA_W-1:0] req0_rdata;
  logic [DATA_W-1:0] req1_rdata;
  logic              req0_err;
  logic              req1_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    input  req0_valid, req1_valid, req0_write, req1_write,
    input  req0_addr, req1_addr, req0_wdata, req1_wdata,
    output req0_done, req1_done, req0_rdata, req1_rdata, req0_err, req1_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA
  );

  modport slave (
    output req0_valid, req1_valid, req0_write, req1_write,
    output req0_addr, req1_addr, req0_wdata, req1_wdata,
    input  req0_done, req1_done, req0_rdata, req1_rdata, req0_err, req1_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA
  );
endinterface

// File: rtl/apb_arbiter_master.sv
// Round-robin two-requester APB master sharing one slave; all outputs registered.
// Define APB_ARB_TIMEOUT_EN to abort transfers whose PREADY stays low for TIMEOUT ACCESS cycles.
module apb_arbiter_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
`ifdef APB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_arbiter_master_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic              elig0_s, elig1_s, win_s, complete_s, timeout_s;
  logic [DATA_W-1:0] cap_data_s;

  // A requester still seeing its done pulse is dropping that request, so it may not win.
  assign elig0_s    = bus.req0_valid & ~done0_q;
  assign elig1_s    = bus.req1_valid & ~done1_q;
  assign win_s      = (elig0_s & elig1_s) ? ~last_q : elig1_s;
  assign complete_s = (state_q == ST_ACCESS) & (bus.PREADY | timeout_s);
  assign cap_data_s = (pwrite_q | timeout_s) ? {DATA_W{1'b0}} : bus.PRDATA;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count PREADY-low ACCESS cycles; PREADY on the limit cycle still wins.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_s = 1'b0;
    if ((state_q == ST_ACCESS) && !bus.PREADY) begin
      cnt_d     = cnt_q + CNT_W'(1);
      timeout_s = (cnt_d == CNT_W'(TIMEOUT));
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Timeout counter register.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, arbitration and completion capture.
  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    grant_d  = grant_q;
    last_d   = last_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    case (state_q)
      ST_IDLE: begin
        if (elig0_s | elig1_s) begin
          state_d  = ST_SETUP;
          grant_d  = win_s;
          last_d   = win_s;
          pwrite_d = win_s ? bus.req1_write : bus.req0_write;
          paddr_d  = win_s ? bus.req1_addr  : bus.req0_addr;
          pwdata_d = win_s ? bus.req1_wdata : bus.req0_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (complete_s) begin
          state_d = ST_IDLE;
          if (grant_q) begin
            done1_d  = 1'b1;
            rdata1_d = cap_data_s;
            err1_d   = timeout_s;
          end else begin
            done0_d  = 1'b1;
            rdata0_d = cap_data_s;
            err0_d   = timeout_s;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= {ADDR_W{1'b0}};
      pwdata_q  <= {DATA_W{1'b0}};
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= {DATA_W{1'b0}};
      rdata1_q  <= {DATA_W{1'b0}};
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign bus.PSEL       = psel_q;
  assign bus.PENABLE    = penable_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PADDR      = paddr_q;
  assign bus.PWDATA     = pwdata_q;
  assign bus.req0_done  = done0_q;
  assign bus.req1_done  = done1_q;
  assign bus.req0_rdata = rdata0_q;
  assign bus.req1_rdata = rdata1_q;
  assign bus.req0_err   = err0_q;
  assign bus.req1_err   = err1_q;

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Directed bench for apb_arbiter_master: vector table of single/dual requests plus
// hand-written contention, timeout (APB_ARB_TIMEOUT_EN) and mid-transfer reset sequences.
module tb_apb_arbiter_master;
  logic PCLK;
  logic PRESET;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   slv_waits;
  int   wait_cnt;
  logic [31:0] mem [0:255];

  apb_arbiter_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  apb_arbiter_master #(
    .ADDR_W(8),
    .DATA_W(32)
`ifdef APB_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Registered-PREADY slave: PREADY rises slv_waits+1 cycles into ACCESS.
  always @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5A000000 | 32'(i);
      bus.PREADY <= 1'b0;
      wait_cnt   <= 0;
    end else if (bus.PSEL && bus.PENABLE && !bus.PREADY) begin
      if (wait_cnt < slv_waits) wait_cnt <= wait_cnt + 1;
      else bus.PREADY <= 1'b1;
    end else begin
      if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR] <= bus.PWDATA;
      bus.PREADY <= 1'b0;
      wait_cnt   <= 0;
    end
  end
  assign bus.PRDATA = mem[bus.PADDR];

  typedef struct {
    logic        v0, v1, w0, w1;
    logic [7:0]  a0, a1;
    logic [31:0] d0, d1;
    int          waits;
    logic        first;
    logic [31:0] rd_first, rd_second;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for a done pulse, checking the APB phases of the transfer on the way.
  task automatic wait_done(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                           output int lat);
    bit ok   = 1'b1;
    bit seen = 1'b0;
    lat = 0;
    while (!seen && lat < 60) begin
      @(posedge PCLK);
      @(negedge PCLK);
      lat++;
      if (bus.req0_done || bus.req1_done) begin
        seen = 1'b1;
      end else if (bus.PSEL !== 1'b1 || bus.PENABLE !== (lat >= 2) || bus.PADDR !== addr ||
                   bus.PWRITE !== wr || (wr && bus.PWDATA !== wd)) begin
        ok = 1'b0;
      end
    end
    check("done_within_bound", seen, 1);
    check("apb_phases_stable", ok, 1);
  endtask

  initial begin
    vec_t vecs [8];
    vec_t v;
    int   lat, k, prev;
    int   r0, r1;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 32'h0, 32'h0, 0, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h30, 32'h12345678, 32'hCAFEF00D, 0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 8'h00, 32'h0, 32'h0, 5, 1'b0, 32'hCAFEF00D, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 32'h0, 32'h0, 1, 1'b1, 32'h12345678, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 32'h0, 32'hA5A5A5A5, 0, 1'b1, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 32'h0, 32'h0, 2, 1'b0, 32'hA5A5A5A5, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 32'h0, 0, 1'b1, 32'h5A000000, 32'h0};

    PRESET = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = 8'h00; bus.req0_wdata = 32'h0;
    bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = 8'h00; bus.req1_wdata = 32'h0;
    slv_waits = 0;
    #2 PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    check("reset_apb_outputs", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, 0);
    check("reset_req_outputs", {bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err}, 0);
    check("reset_rdata", {bus.req0_rdata, bus.req1_rdata}, 0);
    PRESET = 1'b1;
    @(negedge PCLK);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      bus.req0_valid = v.v0; bus.req0_write = v.w0; bus.req0_addr = v.a0; bus.req0_wdata = v.d0;
      bus.req1_valid = v.v1; bus.req1_write = v.w1; bus.req1_addr = v.a1; bus.req1_wdata = v.d1;
      slv_waits = v.waits;
      if (v.first) wait_done(v.a1, v.w1, v.d1, lat);
      else wait_done(v.a0, v.w0, v.d0, lat);
      check("first_grant", {bus.req0_done, bus.req1_done}, v.first ? 2'b01 : 2'b10);
      check("first_latency", lat, 4 + v.waits);
      check("first_rdata", v.first ? bus.req1_rdata : bus.req0_rdata, v.rd_first);
      check("first_err", {bus.req0_err, bus.req1_err}, 0);
      if (v.first) bus.req1_valid = 1'b0;
      else bus.req0_valid = 1'b0;
      if (v.v0 && v.v1) begin
        if (v.first) wait_done(v.a0, v.w0, v.d0, lat);
        else wait_done(v.a1, v.w1, v.d1, lat);
        check("second_grant", {bus.req0_done, bus.req1_done}, v.first ? 2'b10 : 2'b01);
        check("second_spacing", lat, 4 + v.waits);
        check("second_rdata", v.first ? bus.req0_rdata : bus.req1_rdata, v.rd_second);
        check("second_err", {bus.req0_err, bus.req1_err}, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      @(negedge PCLK);
      check("done_one_cycle", {bus.req0_done, bus.req1_done}, 2'b00);
      if (i == 0) check("slave_mem_write", mem[8'h10], 32'hDEADBEEF);
    end

    // Both requesters hold three requests each: grants must alternate 4 cycles apart.
    slv_waits = 0;
    r0 = 3; r1 = 3; k = 0; lat = 0; prev = 0;
    bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 8'h40; bus.req0_wdata = 32'h11110000;
    bus.req1_valid = 1'b1; bus.req1_write = 1'b1; bus.req1_addr = 8'h50; bus.req1_wdata = 32'h22220000;
    while (k < 6 && lat < 100) begin
      @(posedge PCLK);
      @(negedge PCLK);
      lat++;
      if (bus.req0_done || bus.req1_done) begin
        check("contention_grant", {bus.req0_done, bus.req1_done}, (k % 2 == 0) ? 2'b10 : 2'b01);
        check("contention_spacing", lat - prev, 4);
        prev = lat;
        k++;
        if (bus.req0_done) begin
          r0--;
          if (r0 == 0) bus.req0_valid = 1'b0;
          else bus.req0_addr = bus.req0_addr + 8'h01;
        end else begin
          r1--;
          if (r1 == 0) bus.req1_valid = 1'b0;
          else bus.req1_addr = bus.req1_addr + 8'h01;
        end
      end
    end
    check("contention_count", k, 6);
    @(negedge PCLK);

`ifdef APB_ARB_TIMEOUT_EN
    slv_waits = 1000;
    bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 8'h07;
    wait_done(8'h07, 1'b0, 32'h0, lat);
    check("timeout_latency", lat, 18);
    check("timeout_done_err", {bus.req0_done, bus.req0_err}, 2'b11);
    check("timeout_rdata", bus.req0_rdata, 0);
    bus.req0_valid = 1'b0;
    slv_waits = 0;
    @(negedge PCLK);
    bus.req0_valid = 1'b1;
    wait_done(8'h07, 1'b0, 32'h0, lat);
    check("after_timeout_latency", lat, 4);
    check("after_timeout_err", bus.req0_err, 0);
    check("after_timeout_rdata", bus.req0_rdata, 32'h5A000007);
    bus.req0_valid = 1'b0;
    @(negedge PCLK);
`endif

    // Reset in the middle of a long ACCESS; pointer must come back to favour req0.
    slv_waits = 10;
    bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 8'h05;
    repeat (3) @(negedge PCLK);
    check("in_access_before_reset", {bus.PSEL, bus.PENABLE}, 2'b11);
    #2 PRESET = 1'b0;
    #1 check("reset_async_drop", {bus.PSEL, bus.PENABLE}, 2'b00);
    bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 8'h10;
    slv_waits = 0;
    k = 0;
    repeat (2) begin
      @(negedge PCLK);
      if (bus.req0_done || bus.req1_done) k++;
    end
    check("no_done_in_reset", k, 0);
    PRESET = 1'b1;
    wait_done(8'h05, 1'b0, 32'h0, lat);
    check("post_reset_grant", {bus.req0_done, bus.req1_done}, 2'b10);
    check("post_reset_latency", lat, 4);
    check("post_reset_rdata0", bus.req0_rdata, 32'h5A000005);
    bus.req0_valid = 1'b0;
    wait_done(8'h10, 1'b0, 32'h0, lat);
    check("post_reset_second", {bus.req0_done, bus.req1_done}, 2'b01);
    check("post_reset_spacing", lat, 4);
    check("post_reset_rdata1", bus.req1_rdata, 32'h5A000010);
    bus.req1_valid = 1'b0;
    @(negedge PCLK);
    check("final_idle", {bus.req0_done, bus.req1_done, bus.PSEL}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
